regfile_sb: RTL and testbench

Parametrised register file with integrated scoreboard for SimpleCore-class pipelines: N general-purpose registers, two read ports, one writeback port, and the top index mapped read-only onto the program counter. The file tracks per-register pending-write (busy) bits so that issue logic can reserve a destination, stall on busy sources, and have the reservation cleared by writeback. It sits between decode/issue (read, reserve) and the writeback stage (write, release).

---
 rtl/regfile_sb_pkg.sv | 14 +
 rtl/regfile_sb_if.sv | 41 ++++
 rtl/regfile_sb_rdport.sv | 45 ++++
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb shared constants and helpers.
// Optional same-cycle write bypass: REGFILE_BYPASS_EN.
package regfile_sb_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_NREG = 16;
  localparam int RST_VAL  = 0;

  // Top index is the read-only PC alias.
  function automatic int pcAlias(input int nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb bus: read ports, writeback, reserve, status.
// Optional same-cycle write bypass: REGFILE_BYPASS_EN.
interface regfile_sb_if #(
  parameter int DW   = 16,
  parameter int NREG = 16
) ();
  localparam int IW = $clog2(NREG);

  logic [IW-1:0] rdAIdx;
  logic [IW-1:0] rdBIdx;
  logic          rdAOEn;
  logic          rdBOEn;
  logic [DW-1:0] rdAData;
  logic [DW-1:0] rdBData;
  logic          rdABusy;
  logic          rdBBusy;
  logic          wbEn;
  logic [IW-1:0] wbIdx;
  logic [DW-1:0] wbData;
  logic          rsvEn;
  logic [IW-1:0] rsvIdx;
  logic          rsvAck;
  logic [DW-1:0] pc;
  logic [IW:0]   busyCnt;

  modport master (
    output rdAIdx, rdBIdx, rdAOEn, rdBOEn,
    output wbEn, wbIdx, wbData,
    output rsvEn, rsvIdx, pc,
    input  rdAData, rdBData, rdABusy, rdBBusy,
    input  rsvAck, busyCnt
  );

  modport slave (
    input  rdAIdx, rdBIdx, rdAOEn, rdBOEn,
    input  wbEn, wbIdx, wbData,
    input  rsvEn, rsvIdx, pc,
    output rdAData, rdBData, rdABusy, rdBBusy,
    output rsvAck, busyCnt
  );
endinterface

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: mux, gating, busy lookup.
// Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  localparam int IW  = $clog2(NREG)
) (
  input  logic [IW-1:0]           idx,
  input  logic                    oEn,
  input  logic [NREG-1:0][DW-1:0] tbl,
  input  logic [NREG-1:0]         busy,
  input  logic                    wbEn,
  input  logic [IW-1:0]           wbIdx,
  input  logic [DW-1:0]           wbData,
  output logic [DW-1:0]           data,
  output logic                    busyOut
);

  localparam logic [IW-1:0] PCIDX = IW'(pcAlias(NREG));

  logic isPc;
  assign isPc = (idx == PCIDX);

`ifdef REGFILE_BYPASS_EN
  logic hit;
  assign hit = wbEn && (wbIdx == idx) && !isPc;
`else
  logic hit;
  logic unusedBp;
  assign hit      = 1'b0;
  assign unusedBp = ^{wbEn, wbIdx, wbData};
`endif

  always_comb begin
    data    = '0;
    busyOut = 1'b0;
    if (oEn) begin
      data    = hit ? wbData : tbl[idx];
      busyOut = busy[idx] && !hit;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and PC alias.
// Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave rf
);

  localparam int IW = $clog2(NREG);
  localparam int NS = NREG - 1;
  localparam logic [IW-1:0] PCIDX = IW'(pcAlias(NREG));

  logic [NS-1:0][DW-1:0]   regs;
  logic [NS-1:0]           busy;
  logic [NS-1:0]           busyNext;
  logic [IW:0]             cntNext;
  logic [IW:0]             cnt;
  logic [NREG-1:0][DW-1:0] tbl;
  logic [NREG-1:0]         busyExt;
  logic                    wbHit;
  logic                    rsvAck;

  // PC sits in the top slot; it never reports busy.
  assign tbl     = {rf.pc, regs};
  assign busyExt = {1'b0, busy};
  assign wbHit   = rf.wbEn && (rf.wbIdx != PCIDX);

  assign rsvAck = rf.rsvEn && (rf.rsvIdx != PCIDX) &&
                  (!busyExt[rf.rsvIdx] ||
                   (rf.wbEn && rf.wbIdx == rf.rsvIdx));

  assign rf.rsvAck  = rsvAck;
  assign rf.busyCnt = cnt;

  // Release first, then reserve, so a same-index pair ends busy.
  always_comb begin
    busyNext = busy;
    cntNext  = '0;
    for (int i = 0; i < NS; i++) begin
      if (wbHit && rf.wbIdx == IW'(i))
        busyNext[i] = 1'b0;
      if (rsvAck && rf.rsvIdx == IW'(i))
        busyNext[i] = 1'b1;
      cntNext = cntNext + (IW+1)'(busyNext[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= {NS{DW'(RST_VAL)}};
      busy <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < NS; i++)
        if (wbHit && rf.wbIdx == IW'(i))
          regs[i] <= rf.wbData;
      busy <= busyNext;
      cnt  <= cntNext;
    end
  end

  regfile_sb_rdport #(.DW(DW), .NREG(NREG)) uRdA (
    .idx    (rf.rdAIdx),
    .oEn    (rf.rdAOEn),
    .tbl    (tbl),
    .busy   (busyExt),
    .wbEn   (rf.wbEn),
    .wbIdx  (rf.wbIdx),
    .wbData (rf.wbData),
    .data   (rf.rdAData),
    .busyOut(rf.rdABusy)
  );

  regfile_sb_rdport #(.DW(DW), .NREG(NREG)) uRdB (
    .idx    (rf.rdBIdx),
    .oEn    (rf.rdBOEn),
    .tbl    (tbl),
    .busy   (busyExt),
    .wbEn   (rf.wbEn),
    .wbIdx  (rf.wbIdx),
    .wbData (rf.wbData),
    .data   (rf.rdBData),
    .busyOut(rf.rdBBusy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (vector table + scoreboard).
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_sb_if #(.DW(16), .NREG(16)) rf ();

  regfile_sb #(.DW(16), .NREG(16)) dut (
    .clk(clk),
    .rst(rst),
    .rf (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a, b;
    logic        aOe, bOe, wbEn;
    logic [3:0]  wbIdx;
    logic [15:0] wbData;
    logic        rsvEn;
    logic [3:0]  rsvIdx;
    logic [15:0] eA, eB;
    logic        eAB, eBB, eAck;
    logic [4:0]  eCnt;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];

  function automatic vec_t mk(
    input logic [3:0] a, input logic [3:0] b,
    input logic aOe, input logic bOe,
    input logic wbEn, input logic [3:0] wbIdx,
    input logic [15:0] wbData,
    input logic rsvEn, input logic [3:0] rsvIdx,
    input logic [15:0] eA, input logic [15:0] eB,
    input logic eAB, input logic eBB,
    input logic eAck, input logic [4:0] eCnt);
    vec_t v;
    v.a = a; v.b = b; v.aOe = aOe; v.bOe = bOe;
    v.wbEn = wbEn; v.wbIdx = wbIdx; v.wbData = wbData;
    v.rsvEn = rsvEn; v.rsvIdx = rsvIdx;
    v.eA = eA; v.eB = eB; v.eAB = eAB; v.eBB = eBB;
    v.eAck = eAck; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic applyVec(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    rf.rdAIdx = v.a;    rf.rdBIdx = v.b;
    rf.rdAOEn = v.aOe;  rf.rdBOEn = v.bOe;
    rf.wbEn   = v.wbEn; rf.wbIdx  = v.wbIdx;
    rf.wbData = v.wbData;
    rf.rsvEn  = v.rsvEn; rf.rsvIdx = v.rsvIdx;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, " rdAData"}, rf.rdAData, e.eA);
    chk({tag, " rdBData"}, rf.rdBData, e.eB);
    chk({tag, " rdABusy"}, 16'(rf.rdABusy), 16'(e.eAB));
    chk({tag, " rdBBusy"}, 16'(rf.rdBBusy), 16'(e.eBB));
    chk({tag, " rsvAck"}, 16'(rf.rsvAck), 16'(e.eAck));
    chk({tag, " busyCnt"}, 16'(rf.busyCnt), 16'(e.eCnt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rf.rdAIdx = '0; rf.rdBIdx = '0;
    rf.rdAOEn = 1'b1; rf.rdBOEn = 1'b1;
    rf.wbEn = 1'b0; rf.wbIdx = '0; rf.wbData = '0;
    rf.rsvEn = 1'b0; rf.rsvIdx = '0;
    rf.pc = 16'h0100;

    //            a  b  aOe bOe wb wIdx wData     rsv rIdx eA        eB        aB bB ack cnt
    vecs[0]  = mk(0, 15, 1, 1, 0, 0,  16'h0000, 0, 0,  16'h0000, 16'h0100, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2,  1, 1, 1, 3,  16'hA5A5, 0, 0,  16'h0000, 16'h0000, 0, 0, 0, 0);
    vecs[2]  = mk(3, 3,  1, 1, 0, 0,  16'h0000, 0, 0,  16'hA5A5, 16'hA5A5, 0, 0, 0, 0);
    vecs[3]  = mk(15, 3, 1, 1, 1, 15, 16'hDEAD, 0, 0,  16'h0100, 16'hA5A5, 0, 0, 0, 0);
    vecs[4]  = mk(15, 3, 1, 1, 0, 0,  16'h0000, 0, 0,  16'h0100, 16'hA5A5, 0, 0, 0, 0);
    vecs[5]  = mk(5, 4,  1, 1, 0, 0,  16'h0000, 1, 5,  16'h0000, 16'h0000, 0, 0, 1, 0);
    vecs[6]  = mk(5, 4,  1, 1, 0, 0,  16'h0000, 1, 5,  16'h0000, 16'h0000, 1, 0, 0, 1);
    vecs[7]  = mk(6, 3,  1, 1, 1, 5,  16'h1234, 0, 0,  16'h0000, 16'hA5A5, 0, 0, 0, 1);
    vecs[8]  = mk(5, 5,  1, 1, 0, 0,  16'h0000, 0, 0,  16'h1234, 16'h1234, 0, 0, 0, 0);
    vecs[9]  = mk(7, 5,  1, 1, 0, 0,  16'h0000, 1, 7,  16'h0000, 16'h1234, 0, 0, 1, 0);
    vecs[10] = mk(3, 5,  1, 1, 1, 7,  16'h7777, 1, 7,  16'hA5A5, 16'h1234, 0, 0, 1, 1);
    vecs[11] = mk(7, 7,  1, 1, 0, 0,  16'h0000, 0, 0,  16'h7777, 16'h7777, 1, 1, 0, 1);
    vecs[12] = mk(15, 0, 1, 1, 0, 0,  16'h0000, 1, 15, 16'h0100, 16'h0000, 0, 0, 0, 1);
    vecs[13] = mk(7, 3,  1, 1, 1, 1,  16'hFFFF, 1, 1,  16'h7777, 16'hA5A5, 1, 0, 1, 1);
    vecs[14] = mk(1, 1,  0, 1, 0, 0,  16'h0000, 0, 0,  16'h0000, 16'hFFFF, 0, 1, 0, 2);
    vecs[15] = mk(1, 7,  0, 1, 0, 0,  16'h0000, 1, 1,  16'h0000, 16'h7777, 0, 1, 0, 2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      applyVec(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset mid-run with r1/r7 busy and data stored.
    @(posedge clk);
    #1;
    rf.wbEn = 1'b0; rf.rsvEn = 1'b0;
    rf.rdAOEn = 1'b1; rf.rdAIdx = 4'd7;
    #1;
    rst = 1'b1;
    #1;
    chk("rst busyCnt", 16'(rf.busyCnt), 16'd0);
    chk("rst rdABusy", 16'(rf.rdABusy), 16'd0);
    for (int i = 0; i < 15; i++) begin
      rf.rdAIdx = 4'(i);
      #0.5;
      chk($sformatf("rst r%0d", i), rf.rdAData, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;

`ifdef REGFILE_BYPASS_EN
    applyVec(mk(0, 0, 1, 1, 1, 2, 16'h1111, 1, 2,
                16'h0000, 16'h0000, 0, 0, 1, 0), "bp0");
    applyVec(mk(2, 2, 1, 1, 1, 2, 16'hBEEF, 0, 0,
                16'hBEEF, 16'hBEEF, 0, 0, 0, 1), "bp1");
`else
    applyVec(mk(0, 0, 1, 1, 1, 2, 16'h1111, 1, 2,
                16'h0000, 16'h0000, 0, 0, 1, 0), "bp0");
    applyVec(mk(2, 2, 1, 1, 1, 2, 16'hBEEF, 0, 0,
                16'h1111, 16'h1111, 1, 1, 0, 1), "bp1");
`endif
    applyVec(mk(2, 2, 1, 1, 0, 0, 16'h0000, 0, 0,
                16'hBEEF, 16'hBEEF, 0, 0, 0, 0), "bp2");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
